// File: rtl/ncore_rst_pkg.sv
// Shared definitions for the Ncore reset sequencer: sequencer state encoding,
// minimum synchroniser depth and a width helper for counters and indices.
package ncore_rst_pkg;

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        STAGGER  = 3'd1,
        WAIT_ACK = 3'd2,
        NEXT     = 3'd3,
        DONE     = 3'd4
    } seq_state_e;

    localparam int NCORE_RST_SYNC_MIN = 2;

    // Bits needed to hold the values 0..n_values-1, never less than one.
    function automatic int width_of(input int n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

// File: rtl/ncore_rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES
// rising edges of clk_fr.
//   clk_fr   in   free-running clock
//   rst      in   raw reset, asynchronous, active-low
//   rst_sync out  synchronised reset, active-low
module ncore_rst_sync
    import ncore_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_fr,
    input  logic rst,
    output logic rst_sync
);

    // A chain shorter than two flops gives no metastability protection.
    localparam int STAGES = (SYNC_STAGES < NCORE_RST_SYNC_MIN) ? NCORE_RST_SYNC_MIN : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/ncore_rst_sequencer.sv
// Staged per-domain reset release for the Ncore DUT. Reset assertion is
// asynchronous; release is synchronised and then walks the domains in index
// order, each release preceded by a stagger delay and optionally followed by
// a bounded wait for that domain's ready acknowledge.
//   clk_fr        in   free-running clock
//   rst           in   raw reset, asynchronous, active-low
//   soft_rst_req  in   single-cycle pulse, re-runs the sequence
//   dom_ack       in   per-domain ready (level)
//   rst_dom_n     out  per-domain reset, active-low, straight from flops
//   seq_done      out  all domains released
//   timeout_err   out  sticky, some acknowledge timed out
//   err_domain    out  domain index of the first timeout
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SYNC     | waiting for the synchronised raw reset to deassert
// STAGGER  | counting down before releasing domain idx
// WAIT_ACK | domain idx released, waiting for dom_ack[idx] or timeout
// NEXT     | domain idx released without ack wait, advance to next domain
// DONE     | every domain released
module ncore_rst_sequencer
    import ncore_rst_pkg::*;
#(
    parameter int                     NUM_DOMAINS    = 4,
    parameter int                     SYNC_STAGES    = 2,
    parameter int                     STAGGER_CYCLES = 8,
    parameter logic [NUM_DOMAINS-1:0] ACK_MASK       = '1,
    parameter int                     ACK_TIMEOUT    = 255
) (
    input  logic                                clk_fr,
    input  logic                                rst,
    input  logic                                soft_rst_req,
    input  logic [NUM_DOMAINS-1:0]              dom_ack,
    output logic [NUM_DOMAINS-1:0]              rst_dom_n,
    output logic                                seq_done,
    output logic                                timeout_err,
    output logic [width_of(NUM_DOMAINS)-1:0]    err_domain
);

    localparam int IDX_W  = width_of(NUM_DOMAINS);
    localparam int CNT_W  = width_of(STAGGER_CYCLES);
    localparam int TCNT_W = width_of(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TIMEOUT_VAL  = TCNT_W'(ACK_TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

    logic                   rst_sync;
    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic [NUM_DOMAINS-1:0] rst_dom_q, rst_dom_d;
    logic                   seq_done_q, seq_done_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0]       err_domain_q, err_domain_d;
    logic [NUM_DOMAINS-1:0] idx_bit;
    logic                   advance;

    ncore_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_fr   (clk_fr),
        .rst      (rst),
        .rst_sync (rst_sync)
    );

    assign idx_bit = NUM_DOMAINS'(1) << idx_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        rst_dom_d     = rst_dom_q;
        seq_done_d    = seq_done_q;
        timeout_err_d = timeout_err_q;
        err_domain_d  = err_domain_q;
        advance       = 1'b0;

        if (soft_rst_req && (state_q != SYNC)) begin
            // Error status survives a soft re-run so software can still read it.
            state_d    = STAGGER;
            idx_d      = '0;
            cnt_d      = STAGGER_LOAD;
            tcnt_d     = '0;
            rst_dom_d  = '0;
            seq_done_d = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (rst_sync) begin
                        cnt_d   = STAGGER_LOAD;
                        state_d = STAGGER;
                    end
                end
                STAGGER: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rst_dom_d = rst_dom_q | idx_bit;
                        // Done means "all released", so it rises with the last release.
                        if (idx_q == LAST_IDX) begin
                            seq_done_d = 1'b1;
                        end
                        tcnt_d  = '0;
                        state_d = ACK_MASK[idx_q] ? WAIT_ACK : NEXT;
                    end
                end
                WAIT_ACK: begin
                    // Leaving WAIT_ACK advances directly, so an ack-tied domain
                    // costs the same as a domain that skips the ack wait.
                    if (dom_ack[idx_q]) begin
                        advance = 1'b1;
                    end else if (tcnt_q == TIMEOUT_VAL) begin
                        timeout_err_d = 1'b1;
                        if (!timeout_err_q) begin
                            err_domain_d = idx_q;
                        end
                        advance = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
                NEXT: begin
                    advance = 1'b1;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase

            if (advance) begin
                if (idx_q == LAST_IDX) begin
                    state_d    = DONE;
                    seq_done_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    cnt_d   = STAGGER_LOAD;
                    state_d = STAGGER;
                end
            end
        end
    end

    always_ff @(posedge clk_fr or negedge rst) begin
        if (!rst) begin
            state_q       <= SYNC;
            idx_q         <= '0;
            cnt_q         <= '0;
            tcnt_q        <= '0;
            rst_dom_q     <= '0;
            seq_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            err_domain_q  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
            rst_dom_q     <= rst_dom_d;
            seq_done_q    <= seq_done_d;
            timeout_err_q <= timeout_err_d;
            err_domain_q  <= err_domain_d;
        end
    end

    assign rst_dom_n   = rst_dom_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = timeout_err_q;
    assign err_domain  = err_domain_q;

endmodule
